// File: rtl/pindriver.sv
// Tri-state pin driver: hi-Z guard before driving, minimum pulse width on level
// changes, and a short hold of the driven level after the request drops.
module pindriver #(
  parameter int GUARD_TICKS = 2,
  parameter int HOLD_TICKS  = 1,
  parameter int MIN_WIDTH   = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ena,
  input  logic drv_req,
  input  logic din,
  output logic dout,
  output logic oe,
  output logic busy,
  output logic changed
);

  typedef enum logic [1:0] {S_IDLE, S_GUARD, S_DRIVE, S_HOLD} state_t;

  localparam logic [3:0] GUARD_LAST = 4'(GUARD_TICKS - 1);
  localparam logic [3:0] HOLD_LAST  = 4'(HOLD_TICKS - 1);
  localparam logic [3:0] WIDTH_LAST = 4'(MIN_WIDTH - 1);

  state_t     state_q, state_d;
  logic [3:0] tcnt_q, tcnt_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic       dout_q, dout_d;
  logic       oe_q, oe_d;
  logic       changed_q, changed_d;

  logic [3:0] wcnt_inc;
  logic       accept;

  // wcnt saturates so a long-settled level accepts a new din immediately
  assign wcnt_inc = (wcnt_q >= WIDTH_LAST) ? WIDTH_LAST : wcnt_q + 4'd1;
  assign accept   = drv_req && (din != dout_q) && (wcnt_q >= WIDTH_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ena) begin
      case (state_q)
        S_IDLE:  if (drv_req) state_d = S_GUARD;
        S_GUARD: begin
          if (!drv_req)                 state_d = S_IDLE;
          else if (tcnt_q == GUARD_LAST) state_d = S_DRIVE;
        end
        S_DRIVE: if (!drv_req) state_d = S_HOLD;
        S_HOLD: begin
          if (drv_req)                  state_d = S_DRIVE;
          else if (tcnt_q == HOLD_LAST) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    tcnt_d    = tcnt_q;
    wcnt_d    = wcnt_q;
    dout_d    = dout_q;
    changed_d = 1'b0;
    if (ena) begin
      case (state_q)
        S_IDLE: begin
          if (drv_req) begin
            dout_d = din;
            tcnt_d = 4'd0;
          end
        end
        S_GUARD: begin
          dout_d = din;
          if (drv_req) begin
            if (tcnt_q == GUARD_LAST) wcnt_d = 4'd0;
            else                      tcnt_d = tcnt_q + 4'd1;
          end
        end
        S_DRIVE: begin
          if (!drv_req) begin
            tcnt_d = 4'd0;
            wcnt_d = wcnt_inc;
          end else if (accept) begin
            dout_d    = din;
            wcnt_d    = 4'd0;
            changed_d = 1'b1;
          end else begin
            wcnt_d = wcnt_inc;
          end
        end
        S_HOLD: begin
          wcnt_d = wcnt_inc;
          if (!drv_req && tcnt_q != HOLD_LAST) tcnt_d = tcnt_q + 4'd1;
        end
        default: ;
      endcase
    end
    // oe tracks the registered state so it never depends combinationally on inputs
    oe_d = (state_d == S_DRIVE) || (state_d == S_HOLD);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt_q    <= 4'd0;
      wcnt_q    <= 4'd0;
      dout_q    <= 1'b1;
      oe_q      <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      tcnt_q    <= tcnt_d;
      wcnt_q    <= wcnt_d;
      dout_q    <= dout_d;
      oe_q      <= oe_d;
      changed_q <= changed_d;
    end
  end

  always_comb begin
    busy    = (state_q != S_IDLE);
    dout    = dout_q;
    oe      = oe_q;
    changed = changed_q;
  end

endmodule

// File: tb/tb_pindriver.sv
// Bench for pindriver: fixed vector table, hand sequences for ena gating and
// async reset, then random traffic against a countdown-based reference model.
module tb_pindriver;

  localparam int GT = 2;
  localparam int HT = 1;
  localparam int MW = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ena = 1'b0;
  logic drv_req = 1'b0;
  logic din = 1'b0;
  logic dout, oe, busy, changed;

  int checks = 0;
  int failures = 0;

  pindriver #(.GUARD_TICKS(GT), .HOLD_TICKS(HT), .MIN_WIDTH(MW)) dut (
    .clk(clk), .reset_n(reset_n), .ena(ena), .drv_req(drv_req), .din(din),
    .dout(dout), .oe(oe), .busy(busy), .changed(changed)
  );

  always #5 clk = ~clk;

  // Reference model: phase plus remaining-tick countdowns and an unbounded level age
  localparam int M_OFF = 0, M_GUARDING = 1, M_ON = 2, M_HOLDING = 3;
  int   m_mode, guard_left, hold_left, age;
  logic m_dout, m_oe, m_changed;

  function automatic void model_reset();
    m_mode = M_OFF; guard_left = 0; hold_left = 0; age = 0;
    m_dout = 1'b1; m_oe = 1'b0; m_changed = 1'b0;
  endfunction

  function automatic void model_step(logic e, logic r, logic d);
    m_changed = 1'b0;
    if (!e) return;
    case (m_mode)
      M_OFF: if (r) begin m_dout = d; guard_left = GT; m_mode = M_GUARDING; end
      M_GUARDING: begin
        m_dout = d;
        if (!r) m_mode = M_OFF;
        else begin
          guard_left--;
          if (guard_left == 0) begin m_mode = M_ON; m_oe = 1'b1; age = 0; end
        end
      end
      M_ON: begin
        if (!r) begin m_mode = M_HOLDING; hold_left = HT; age++; end
        else if (d != m_dout && age >= MW - 1) begin
          m_dout = d; age = 0; m_changed = 1'b1;
        end else age++;
      end
      default: begin
        age++;
        if (r) m_mode = M_ON;
        else begin
          hold_left--;
          if (hold_left == 0) begin m_mode = M_OFF; m_oe = 1'b0; end
        end
      end
    endcase
  endfunction

  function automatic logic [3:0] model_vec();
    return {m_oe, m_dout, (m_mode != M_OFF), m_changed};
  endfunction

  task automatic check(input string name, input logic [3:0] exp);
    logic [3:0] act;
    act = {oe, dout, busy, changed};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: oe/dout/busy/changed got=%b expected=%b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply inputs, clock one edge, advance the model, and sample 1 unit after the edge
  task automatic tick(input logic e, input logic r, input logic d);
    ena = e; drv_req = r; din = d;
    @(posedge clk);
    #1;
    model_step(e, r, d);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 4'b0100);
    reset_n = 1'b1;
  endtask

  typedef struct packed {
    logic       e, r, d;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs [18];
  int   ena_edges;

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 4'b0010};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 4'b0010};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 4'b1010};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 4'b1010};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 4'b1111};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 4'b1110};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 4'b1110};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 4'b0100};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 4'b0010};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 4'b0100};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 4'b0100};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 4'b0010};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 4'b0010};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 4'b1010};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 4'b1010};
    vecs[15] = '{1'b1, 1'b1, 1'b1, 4'b1010};
    vecs[16] = '{1'b1, 1'b1, 1'b1, 4'b1111};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 4'b1110};

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 18; i++) begin
      tick(vecs[i].e, vecs[i].r, vecs[i].d);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // ena every 4th clk: oe must appear on the 3rd ena edge, nothing moves between pulses
    do_reset();
    ena_edges = 0;
    for (int i = 0; i < 16; i++) begin
      tick((i % 4) == 0, 1'b1, 1'b0);
      if ((i % 4) == 0) ena_edges++;
      check($sformatf("ena_gap%0d", i), {(ena_edges >= 3), 1'b0, 1'b1, 1'b0});
    end

    // Async reset while driving 0
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0);
    check("pre_async_rst", 4'b1010);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_now", 4'b0100);
    @(posedge clk);
    #1;
    check("async_rst_held", 4'b0100);
    reset_n = 1'b1;
    tick(1'b1, 1'b1, 1'b0);
    check("after_rst_idle", 4'b0010);

    // Randomized traffic against the model
    do_reset();
    begin
      logic r, d;
      r = 1'b0; d = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 5) == 0) r = ~r;
        if ($urandom_range(0, 2) == 0) d = ~d;
        tick($urandom_range(0, 3) != 0, r, d);
        check($sformatf("rand%0d", i), model_vec());
        if ($urandom_range(0, 299) == 0) begin
          #2;
          reset_n = 1'b0;
          #1;
          model_reset();
          check($sformatf("rand_rst%0d", i), model_vec());
          @(posedge clk);
          #1;
          reset_n = 1'b1;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
